// File: rtl/vga_timing_master.sv
// rtl/vga_timing_master.sv - VGA timing master with valid/ready pixel pull, underflow and SOF checking
module vga_timing_master #(
  parameter int HORIZ_SYNC         = 96,
  parameter int HORIZ_BACK_PORCH   = 48,
  parameter int HORIZ_ACTIVE_WIDTH = 640,
  parameter int HORIZ_FRONT_PORCH  = 16,
  parameter int VERT_SYNC          = 2,
  parameter int VERT_BACK_PORCH    = 33,
  parameter int VERT_ACTIVE_HEIGHT = 480,
  parameter int VERT_FRONT_PORCH   = 10,
  parameter int COLOUR_DEPTH       = 8,
  parameter logic [3*COLOUR_DEPTH-1:0] UNDERFLOW_COLOUR = 24'hFF00FF
) (
  input  logic                      PCLK,
  input  logic                      RST_N,
  input  logic                      EN,
  input  logic                      CLR_STATUS,
  input  logic                      PIX_VALID,
  output logic                      PIX_READY,
  input  logic [3*COLOUR_DEPTH-1:0] PIX_DATA,
  input  logic                      PIX_SOF,
  output logic                      FRAME_START,
  output logic                      VSYNC_OUT,
  output logic                      HSYNC_OUT,
  output logic [COLOUR_DEPTH-1:0]   RED_OUT,
  output logic [COLOUR_DEPTH-1:0]   GREEN_OUT,
  output logic [COLOUR_DEPTH-1:0]   BLUE_OUT,
  output logic                      UNDERFLOW,
  output logic                      SYNC_ERR,
  output logic [15:0]               UNDERFLOW_CNT
);

  localparam int HTOTAL = HORIZ_SYNC + HORIZ_BACK_PORCH + HORIZ_ACTIVE_WIDTH + HORIZ_FRONT_PORCH;
  localparam int VTOTAL = VERT_SYNC + VERT_BACK_PORCH + VERT_ACTIVE_HEIGHT + VERT_FRONT_PORCH;
  localparam int HW = $clog2(HTOTAL);
  localparam int VW = $clog2(VTOTAL);
  localparam int CW = 3 * COLOUR_DEPTH;

  localparam logic [HW-1:0] H_LAST      = HW'(HTOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END  = HW'(HORIZ_SYNC);
  localparam logic [HW-1:0] H_ACT_START = HW'(HORIZ_SYNC + HORIZ_BACK_PORCH);
  localparam logic [HW-1:0] H_ACT_END   = HW'(HORIZ_SYNC + HORIZ_BACK_PORCH + HORIZ_ACTIVE_WIDTH);
  localparam logic [VW-1:0] V_LAST      = VW'(VTOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END  = VW'(VERT_SYNC);
  localparam logic [VW-1:0] V_ACT_START = VW'(VERT_SYNC + VERT_BACK_PORCH);
  localparam logic [VW-1:0] V_ACT_END   = VW'(VERT_SYNC + VERT_BACK_PORCH + VERT_ACTIVE_HEIGHT);

  logic [HW-1:0] hCnt;
  logic [VW-1:0] vCnt;
  logic          enFrame;
  logic          lastPix;
  logic          act;
  logic          firstPix;
  logic          underflowEvt;
  logic          sofErrEvt;
  logic [CW-1:0] rgbQ;

  assign lastPix  = (hCnt == H_LAST) && (vCnt == V_LAST);
  assign act      = (hCnt >= H_ACT_START) && (hCnt < H_ACT_END) &&
                    (vCnt >= V_ACT_START) && (vCnt < V_ACT_END);
  assign firstPix = (hCnt == H_ACT_START) && (vCnt == V_ACT_START);

  // Ready depends only on screen position and the frame-latched enable, never on PIX_VALID
  assign PIX_READY    = act && enFrame;
  assign underflowEvt = PIX_READY && !PIX_VALID;
  assign sofErrEvt    = PIX_READY && PIX_VALID && (firstPix ? !PIX_SOF : PIX_SOF);

  assign RED_OUT   = rgbQ[CW-1 -: COLOUR_DEPTH];
  assign GREEN_OUT = rgbQ[2*COLOUR_DEPTH-1 -: COLOUR_DEPTH];
  assign BLUE_OUT  = rgbQ[COLOUR_DEPTH-1:0];

  // Raster counters; reset parks them on the last pixel so the first clock opens frame 0
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      hCnt <= H_LAST;
      vCnt <= V_LAST;
    end else if (hCnt == H_LAST) begin
      hCnt <= '0;
      vCnt <= (vCnt == V_LAST) ? '0 : vCnt + VW'(1);
    end else begin
      hCnt <= hCnt + HW'(1);
    end
  end

  // Enable is only sampled on the last pixel so a frame is either fully video or fully blank
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N)       enFrame <= 1'b0;
    else if (lastPix) enFrame <= EN;
  end

  // Syncs, frame pulse and colour all register the same counter snapshot to stay aligned
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      HSYNC_OUT   <= 1'b1;
      VSYNC_OUT   <= 1'b1;
      FRAME_START <= 1'b0;
      rgbQ        <= '0;
    end else begin
      HSYNC_OUT   <= !(hCnt < H_SYNC_END);
      VSYNC_OUT   <= !(vCnt < V_SYNC_END);
      FRAME_START <= (hCnt == '0) && (vCnt == '0);
      if (PIX_READY) rgbQ <= PIX_VALID ? PIX_DATA : UNDERFLOW_COLOUR;
      else           rgbQ <= '0;
    end
  end

  // Sticky status; a new event in the same cycle as a clear takes priority
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      UNDERFLOW     <= 1'b0;
      SYNC_ERR      <= 1'b0;
      UNDERFLOW_CNT <= '0;
    end else begin
      UNDERFLOW <= underflowEvt || (UNDERFLOW && !CLR_STATUS);
      SYNC_ERR  <= sofErrEvt || (SYNC_ERR && !CLR_STATUS);
      if (CLR_STATUS)
        UNDERFLOW_CNT <= underflowEvt ? 16'd1 : 16'd0;
      else if (underflowEvt && (UNDERFLOW_CNT != 16'hFFFF))
        UNDERFLOW_CNT <= UNDERFLOW_CNT + 16'd1;
    end
  end

endmodule
